// File: rtl/wb_master_sequencer_pkg.sv
// Shared types and constants for the NIC WISHBONE master sequencer.
// Bus widths mirror the NIC-wide defines.
package wb_master_sequencer_pkg;

    localparam int BUS_ADDRESS_WIDTH = 32;
    localparam int BUS_DATA_WIDTH    = 32;
    localparam int BUS_SEL_WIDTH     = BUS_DATA_WIDTH / 8;
    localparam int BUS_BYTE_SHIFT    = $clog2(BUS_DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_BUS     = 2'd2,
        ST_BACKOFF = 2'd3
    } seq_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Byte address of a beat inside an incrementing burst; wraps modulo 2^AW.
    function automatic logic [BUS_ADDRESS_WIDTH-1:0] beat_address(
        input logic [BUS_ADDRESS_WIDTH-1:0] base,
        input logic [BUS_ADDRESS_WIDTH-1:0] beat
    );
        return base + (beat << BUS_BYTE_SHIFT);
    endfunction

endpackage

// File: rtl/wb_master_sequencer_if.sv
// WISHBONE master-side bus bundle, including the arbiter request/grant pair.
interface wb_master_sequencer_if;
    import wb_master_sequencer_pkg::*;

    logic                         wb_req_o;
    logic                         wb_gnt_i;
    logic                         wb_cyc_o;
    logic                         wb_stb_o;
    logic                         wb_we_o;
    logic [BUS_ADDRESS_WIDTH-1:0] wb_adr_o;
    logic [BUS_DATA_WIDTH-1:0]    wb_dat_o;
    logic [BUS_SEL_WIDTH-1:0]     wb_sel_o;
    logic [2:0]                   wb_cti_o;
    logic [1:0]                   wb_bte_o;
    logic [BUS_DATA_WIDTH-1:0]    wb_dat_i;
    logic                         wb_ack_i;
    logic                         wb_rty_i;
    logic                         wb_err_i;

    modport master (
        output wb_req_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
               wb_sel_o, wb_cti_o, wb_bte_o,
        input  wb_gnt_i, wb_dat_i, wb_ack_i, wb_rty_i, wb_err_i
    );

    modport slave (
        input  wb_req_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
               wb_sel_o, wb_cti_o, wb_bte_o,
        output wb_gnt_i, wb_dat_i, wb_ack_i, wb_rty_i, wb_err_i
    );

endinterface

// File: rtl/wb_retry_timer.sv
// Back-off delay, retry count and ACK-timeout counters for the master sequencer.
module wb_retry_timer #(
    parameter int RETRY_DELAY = 4,
    parameter int MAX_RETRY   = 8,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic in_backoff,
    input  logic in_bus,
    input  logic retry_clr,
    input  logic retry_inc,
    input  logic timeout_clr,
    output logic backoff_done,
    output logic retry_exhausted,
    output logic timeout
);

    localparam int BO_W = $clog2(RETRY_DELAY + 1);
    localparam int RT_W = $clog2(MAX_RETRY + 1);
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [BO_W-1:0] BO_LAST = BO_W'(RETRY_DELAY - 1);
    localparam logic [RT_W-1:0] RT_LAST = RT_W'(MAX_RETRY - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    logic [BO_W-1:0] bo_cnt;
    logic [RT_W-1:0] retry_cnt;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            bo_cnt    <= '0;
            retry_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            bo_cnt <= in_backoff ? bo_cnt + 1'b1 : '0;

            if (retry_clr)
                retry_cnt <= '0;
            else if (retry_inc)
                retry_cnt <= retry_cnt + 1'b1;

            // Restarts on every non-final ACK so the limit applies per beat.
            if (!in_bus || timeout_clr)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    // Flags describe the current cycle: the event happening now is the last allowed one.
    assign backoff_done    = in_backoff && (bo_cnt == BO_LAST);
    assign retry_exhausted = (retry_cnt == RT_LAST);
    assign timeout         = in_bus && (to_cnt == TO_LAST);

endmodule

// File: rtl/wb_master_sequencer.sv
// WISHBONE master sequencer: turns PACKET2MESSAGE queue heads into single or
// incrementing-burst bus cycles, with RTY back-off, ERR and ACK-timeout aborts.
module wb_master_sequencer
    import wb_master_sequencer_pkg::*;
#(
    parameter int N_BITS_BURST_LENGHT = 7,
    parameter int RETRY_DELAY         = 4,
    parameter int MAX_RETRY           = 8,
    parameter int ACK_TIMEOUT         = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           r_bus_arbitration_i,
    input  logic [BUS_ADDRESS_WIDTH-1:0]   address_i,
    input  logic [BUS_DATA_WIDTH-1:0]      data_i,
    input  logic [BUS_SEL_WIDTH-1:0]       sel_i,
    input  logic                           transaction_type_i,
    input  logic [N_BITS_BURST_LENGHT-1:0] burst_lenght_i,
    output logic                           next_data_o,
    output logic                           retry_o,
    output logic                           message_transmitted_o,
    wb_master_sequencer_if.master          wb,
    output logic [BUS_DATA_WIDTH-1:0]      rd_data_o,
    output logic                           rd_valid_o,
    output logic                           rd_last_o,
    output logic                           error_o
);

    seq_state_t                     state;
    logic                           req_r;
    logic                           cyc_r;
    logic                           type_r;
    logic [N_BITS_BURST_LENGHT-1:0] len_r;
    logic [N_BITS_BURST_LENGHT-1:0] beat_cnt;

    logic backoff_done, retry_exhausted, timeout;
    logic in_bus, last_beat, abort_hit, rty_hit, ack_hit;

    assign in_bus    = (state == ST_BUS);
    assign last_beat = (beat_cnt == len_r - 1'b1);

    // Same-cycle termination priority: ERR/timeout over RTY over ACK.
    assign abort_hit = in_bus && (wb.wb_err_i || timeout);
    assign rty_hit   = in_bus && !abort_hit && wb.wb_rty_i;
    assign ack_hit   = in_bus && !abort_hit && !wb.wb_rty_i && wb.wb_ack_i;

    assign next_data_o           = ack_hit && !last_beat;
    assign retry_o               = abort_hit || rty_hit;
    assign message_transmitted_o = abort_hit || (rty_hit && retry_exhausted) || (ack_hit && last_beat);
    assign error_o               = abort_hit || (rty_hit && retry_exhausted);

    wb_retry_timer #(
        .RETRY_DELAY (RETRY_DELAY),
        .MAX_RETRY   (MAX_RETRY),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_timer (
        .clk             (clk),
        .rst             (rst),
        .in_backoff      (state == ST_BACKOFF),
        .in_bus          (in_bus),
        .retry_clr       (state == ST_IDLE),
        .retry_inc       (rty_hit),
        .timeout_clr     (next_data_o),
        .backoff_done    (backoff_done),
        .retry_exhausted (retry_exhausted),
        .timeout         (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_r      <= 1'b0;
            cyc_r      <= 1'b0;
            type_r     <= 1'b0;
            len_r      <= '0;
            beat_cnt   <= '0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            rd_last_o  <= 1'b0;
        end else begin
            rd_valid_o <= 1'b0;
            rd_last_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    beat_cnt <= '0;
                    if (r_bus_arbitration_i) begin
                        state  <= ST_REQ;
                        req_r  <= 1'b1;
                        type_r <= transaction_type_i;
                        len_r  <= (burst_lenght_i == '0) ? N_BITS_BURST_LENGHT'(1) : burst_lenght_i;
                    end
                end
                ST_REQ: begin
                    beat_cnt <= '0;
                    if (wb.wb_gnt_i) begin
                        state <= ST_BUS;
                        cyc_r <= 1'b1;
                    end
                end
                ST_BUS: begin
                    if (message_transmitted_o) begin
                        state <= ST_IDLE;
                        req_r <= 1'b0;
                        cyc_r <= 1'b0;
                    end else if (rty_hit) begin
                        state <= ST_BACKOFF;
                        req_r <= 1'b0;
                        cyc_r <= 1'b0;
                    end else if (ack_hit) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (ack_hit && !type_r) begin
                        rd_data_o  <= wb.wb_dat_i;
                        rd_valid_o <= 1'b1;
                        rd_last_o  <= last_beat;
                    end
                end
                ST_BACKOFF: begin
                    if (backoff_done) begin
                        state    <= ST_REQ;
                        req_r    <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus-facing outputs are forced to zero whenever no cycle is in progress.
    assign wb.wb_req_o = req_r;
    assign wb.wb_cyc_o = cyc_r;
    assign wb.wb_stb_o = cyc_r;
    assign wb.wb_we_o  = cyc_r && type_r;
    assign wb.wb_adr_o = cyc_r ? beat_address(address_i, BUS_ADDRESS_WIDTH'(beat_cnt)) : '0;
    assign wb.wb_dat_o = cyc_r ? data_i : '0;
    assign wb.wb_sel_o = cyc_r ? sel_i : '0;
    assign wb.wb_cti_o = !cyc_r                      ? CTI_CLASSIC :
                         (len_r == N_BITS_BURST_LENGHT'(1)) ? CTI_CLASSIC :
                         last_beat                   ? CTI_EOB     : CTI_INCR;
    assign wb.wb_bte_o = BTE_LINEAR;

endmodule

// File: doc/wb_master_sequencer.md
Name: wb_master_sequencer

Overview:
Drives the WISHBONE master port of the NIC on behalf of the PACKET2MESSAGE message queue. When the queue head holds a message, the block requests the bus, runs a single or incrementing-burst cycle using the queue's address/data/sel/type/length, and pulses next_data/retry/message_transmitted back to the queue. Also handles RTY back-off, retry exhaustion, ERR and ACK timeout, and returns read-reply beats to the reply path.

Parameters:
N_BITS_BURST_LENGHT, 7, width of burst length and beat counter
RETRY_DELAY, 4, idle cycles between RTY and re-request (>=1)
MAX_RETRY, 8, RTY count that aborts the message (>=1)
ACK_TIMEOUT, 64, cycles without ACK/RTY/ERR in BUS before abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
r_bus_arbitration_i  in  1  queue head holds a message
address_i  in  `BUS_ADDRESS_WIDTH  base address of head message
data_i  in  `BUS_DATA_WIDTH  current write chunk from queue
sel_i  in  `BUS_SEL_WIDTH  current byte select
transaction_type_i  in  1  1=write, 0=read
burst_lenght_i  in  N_BITS_BURST_LENGHT  beats in message
next_data_o  out  1  advance queue chunk pointer
retry_o  out  1  rewind queue chunk pointer
message_transmitted_o  out  1  pop queue head
wb_req_o  out  1  request to bus arbiter
wb_gnt_i  in  1  bus grant
wb_cyc_o / wb_stb_o / wb_we_o  out  1 each  WISHBONE control
wb_adr_o  out  `BUS_ADDRESS_WIDTH  beat address
wb_dat_o  out  `BUS_DATA_WIDTH  write data
wb_sel_o  out  `BUS_SEL_WIDTH  byte select
wb_cti_o  out  3  cycle type identifier
wb_bte_o  out  2  burst type, constant 2'b00
wb_dat_i  in  `BUS_DATA_WIDTH  read data
wb_ack_i / wb_rty_i / wb_err_i  in  1 each  slave termination
rd_data_o  out  `BUS_DATA_WIDTH  registered read beat
rd_valid_o  out  1  rd_data_o valid (one cycle per read ACK)
rd_last_o  out  1  with rd_valid_o: final read beat
error_o  out  1  one-cycle pulse: message dropped

Behaviour:
- One clock; reset synchronous active-high. Reset, including mid-burst: state IDLE, all outputs 0, all counters 0; cyc/stb drop the following edge.
- States: IDLE, REQ, BUS, BACKOFF.
- IDLE: if r_bus_arbitration_i -> REQ; latch transaction_type_i and burst_lenght_i (0 treated as 1) into len_r; clear beat_cnt and retry_cnt.
- REQ: wb_req_o=1; on wb_gnt_i -> BUS next edge; clear beat_cnt and timeout counter.
- BUS: wb_req_o=wb_cyc_o=wb_stb_o=1; wb_we_o=type_r; wb_dat_o=data_i, wb_sel_o=sel_i (combinational passthrough); wb_adr_o=address_i+beat_cnt*(`BUS_DATA_WIDTH/8) (modular). wb_cti_o: 3'b000 if len_r==1, else 3'b111 on last beat, else 3'b010. Grant loss while in BUS is ignored.
- Termination priority, same cycle: err > rty > ack.
- ACK, not last: next_data_o=1 (combinational, same cycle); beat_cnt++; reset timeout counter. Queue presents next chunk in the next cycle.
- ACK on last beat (beat_cnt==len_r-1): message_transmitted_o=1 same cycle -> IDLE. next_data_o stays 0.
- Read ACK: rd_data_o<=wb_dat_i, rd_valid_o=1 next cycle; rd_last_o=1 on final beat.
- RTY: retry_o=1 same cycle; retry_cnt++.
  - New count==MAX_RETRY: also message_transmitted_o=1 and error_o=1 -> IDLE.
  - Otherwise -> BACKOFF; cyc/stb low.
- BACKOFF: counts RETRY_DELAY cycles, then -> REQ; beat_cnt restarts at 0.
- ERR, or timeout counter reaching ACK_TIMEOUT: message_transmitted_o=1, error_o=1, retry_o=1 -> IDLE.
- IDLE never re-enters REQ in the same cycle message_transmitted_o pulses; the queue head updates on that edge.

Decomposition:
- Shared package/defines: state encoding, CTI constants (CTI_CLASSIC, CTI_INCR, CTI_EOB), BTE_LINEAR; bus widths stay in NIC-defines.v.
- Natural sub-module: wb_retry_timer, holding the back-off counter, retry counter and ACK-timeout counter. Exposes backoff_done, retry_exhausted and timeout.

Test Plan:
1. Write, len=1, addr 0x100, ACK on 2nd BUS cycle -> one beat, cti=000, adr=0x100; message_transmitted pulse with ACK; next_data never asserted.
2. Write burst len=4, addr 0x200, 32-bit bus, ACK every cycle -> adr 0x200/204/208/20C; cti 010,010,010,111; 3 next_data pulses then 1 message_transmitted pulse.
3. Read len=4, ACK data 0xA0..0xA3 -> 4 rd_valid pulses with matching rd_data; rd_last on 0xA3; we=0 throughout.
4. Burst len=4, RTY on beat 2 -> retry_o pulse; cyc low for RETRY_DELAY=4 cycles; re-request; restart at base address; full burst completes.
5. RTY on every attempt -> 8th RTY gives message_transmitted+error pulses; exactly 8 REQ phases.
6. Slave silent -> abort after 64 BUS cycles with error_o; then rst asserted mid-burst of next message -> cyc/stb/req low next cycle, state IDLE.
